fdtd_step_sched: RTL

- Timestep scheduler that sequences the FDTD field buffer through one full update per timestep, for a programmed number of timesteps.
- Per timestep: load old Hy, load old Ez (or source), run calculation, write back new Hy, write back new Ez.
- Generates the buffer's start/end pulses, the data-memory word addresses and the write-back enables.
- Sits between the register interface (start, size, step count) and the fdtd_buffer / calc / data-memory ports.

---
 rtl/fdtd_sched_pkg.sv | 29 ++
 rtl/fdtd_xfer_cnt.sv | 34 +++
 rtl/fdtd_step_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fdtd_sched_pkg.sv
// Shared types and constants for the FDTD timestep scheduler.
package fdtd_sched_pkg;

  localparam int FDTD_DATA_WIDTH   = 32;
  localparam int BUFFER_ADDR_WIDTH = 6;
  localparam int FDTD_BUFFER_DEPTH = 64;
  localparam int DM_ADDR_WIDTH     = 16;
  localparam int STEP_CNT_WIDTH    = 16;
  // One extra bit so a full buffer (size == depth) is representable.
  localparam int CNT_W             = BUFFER_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, LD_HY, LD_EZ, CALC, WB_HY, WB_EZ, STEP_END
  } sched_state_e;

  typedef struct packed {
    logic [CNT_W-1:0]          size;
    logic [STEP_CNT_WIDTH-1:0] steps;
    logic                      src_en;
    logic [DM_ADDR_WIDTH-1:0]  hy_base;
    logic [DM_ADDR_WIDTH-1:0]  ez_base;
  } sched_cfg_t;

  function automatic logic cfg_legal(input logic [FDTD_DATA_WIDTH-1:0] size,
                                     input logic [STEP_CNT_WIDTH-1:0]  steps);
    return (size != '0) && (size <= FDTD_DATA_WIDTH'(FDTD_BUFFER_DEPTH)) && (steps != '0);
  endfunction

endpackage

// File: rtl/fdtd_xfer_cnt.sv
// Issue/complete counter pair for one buffer transfer phase (load or write-back).
module fdtd_xfer_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             issue_en,
  input  logic             beat,
  input  logic [CNT_W-1:0] size,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] completed,
  output logic             more,
  output logic             last
);

  assign more = issued < size;
  // Last beat of the phase: the beat that brings completed up to size.
  assign last = beat && ((completed + CNT_W'(1)) == size);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issued    <= '0;
      completed <= '0;
    end else if (clr) begin
      issued    <= '0;
      completed <= '0;
    end else begin
      if (issue_en && more)            issued    <= issued + CNT_W'(1);
      if (beat && (completed != size)) completed <= completed + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fdtd_step_sched.sv
// Sequences the FDTD field buffer through load / calc / write-back for N timesteps.
module fdtd_step_sched
  import fdtd_sched_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start_i,
  input  logic [FDTD_DATA_WIDTH-1:0] buffer_size_i,
  input  logic [STEP_CNT_WIDTH-1:0]  step_num_i,
  input  logic                       src_en_i,
  input  logic [DM_ADDR_WIDTH-1:0]   hy_base_i,
  input  logic [DM_ADDR_WIDTH-1:0]   ez_base_i,
  input  logic                       dm_rvalid_i,
  output logic                       dm_rd_req_o,
  output logic [DM_ADDR_WIDTH-1:0]   dm_rd_addr_o,
  output logic                       wrtvalid_Hy_old_o,
  output logic                       wrtvalid_Ez_old_o,
  output logic                       buffer_Hy_start_o,
  output logic                       buffer_Ez_start_o,
  output logic                       buffer_src_start_o,
  output logic                       buffer_Hy_end_o,
  output logic                       buffer_Ez_end_o,
  output logic                       buffer_src_end_o,
  output logic                       calc_start_o,
  input  logic                       calc_done_i,
  output logic                       mem_rd_Hy_en_o,
  output logic                       mem_rd_Ez_en_o,
  input  logic                       wrtvalid_sgl_i,
  output logic                       mem_rd_end_o,
  output logic [DM_ADDR_WIDTH-1:0]   dm_wr_addr_o,
  output logic [STEP_CNT_WIDTH-1:0]  step_cnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       cfg_err_o
);

  sched_state_e              state_q, state_d;
  sched_cfg_t                cfg_q, cfg_in;
  logic                      entry_q;
  logic [STEP_CNT_WIDTH-1:0] step_cnt_q;
  logic                      cfg_err_q;
  logic                      cfg_ok, is_ld, is_wb, beat, more, last, final_step;
  logic [CNT_W-1:0]          issued, completed;
  logic [DM_ADDR_WIDTH-1:0]  base;

  always_comb begin
    cfg_in.size    = CNT_W'(buffer_size_i);
    cfg_in.steps   = step_num_i;
    cfg_in.src_en  = src_en_i;
    cfg_in.hy_base = hy_base_i;
    cfg_in.ez_base = ez_base_i;
  end

  assign cfg_ok     = cfg_legal(buffer_size_i, step_num_i);
  assign is_ld      = (state_q == LD_HY) || (state_q == LD_EZ);
  assign is_wb      = (state_q == WB_HY) || (state_q == WB_EZ);
  assign base       = ((state_q == LD_HY) || (state_q == WB_HY)) ? cfg_q.hy_base : cfg_q.ez_base;
  assign beat       = (is_ld && dm_rvalid_i) || (is_wb && wrtvalid_sgl_i);
  assign final_step = (step_cnt_q + STEP_CNT_WIDTH'(1)) == cfg_q.steps;

  // Shared by all four transfer phases; cleared on every state change.
  fdtd_xfer_cnt #(.CNT_W(CNT_W)) u_xfer (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (state_d != state_q),
    .issue_en  (is_ld),
    .beat      (beat),
    .size      (cfg_q.size),
    .issued    (issued),
    .completed (completed),
    .more      (more),
    .last      (last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      entry_q    <= 1'b0;
      cfg_q      <= '0;
      step_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      if ((state_q == IDLE) && start_i) begin
        if (cfg_ok) begin
          cfg_q      <= cfg_in;
          step_cnt_q <= '0;
          cfg_err_q  <= 1'b0;
        end else begin
          cfg_err_q  <= 1'b1;
        end
      end
      if (state_q == STEP_END) step_cnt_q <= step_cnt_q + STEP_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d            = state_q;
    dm_rd_req_o        = 1'b0;
    dm_rd_addr_o       = '0;
    dm_wr_addr_o       = '0;
    wrtvalid_Hy_old_o  = 1'b0;
    wrtvalid_Ez_old_o  = 1'b0;
    buffer_Hy_start_o  = 1'b0;
    buffer_Ez_start_o  = 1'b0;
    buffer_src_start_o = 1'b0;
    buffer_Hy_end_o    = 1'b0;
    buffer_Ez_end_o    = 1'b0;
    buffer_src_end_o   = 1'b0;
    calc_start_o       = 1'b0;
    mem_rd_Hy_en_o     = 1'b0;
    mem_rd_Ez_en_o     = 1'b0;
    mem_rd_end_o       = 1'b0;
    done_o             = 1'b0;
    if (is_ld) begin
      dm_rd_req_o  = more;
      dm_rd_addr_o = base + DM_ADDR_WIDTH'(issued);
    end
    if (is_wb) dm_wr_addr_o = base + DM_ADDR_WIDTH'(completed);
    case (state_q)
      IDLE: if (start_i && cfg_ok) state_d = LD_HY;
      LD_HY: begin
        buffer_Hy_start_o = entry_q;
        wrtvalid_Hy_old_o = dm_rvalid_i;
        buffer_Hy_end_o   = last;
        if (last) state_d = LD_EZ;
      end
      LD_EZ: begin
        buffer_Ez_start_o  = entry_q && !cfg_q.src_en;
        buffer_src_start_o = entry_q &&  cfg_q.src_en;
        wrtvalid_Ez_old_o  = dm_rvalid_i;
        buffer_Ez_end_o    = last && !cfg_q.src_en;
        buffer_src_end_o   = last &&  cfg_q.src_en;
        if (last) state_d = CALC;
      end
      CALC: begin
        calc_start_o = entry_q;
        if (calc_done_i) state_d = WB_HY;
      end
      WB_HY: begin
        mem_rd_Hy_en_o = entry_q;
        mem_rd_end_o   = last;
        if (last) state_d = WB_EZ;
      end
      WB_EZ: begin
        mem_rd_Ez_en_o = entry_q;
        mem_rd_end_o   = last;
        if (last) state_d = STEP_END;
      end
      STEP_END: begin
        done_o  = final_step;
        state_d = final_step ? IDLE : LD_HY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign step_cnt_o = step_cnt_q;
  assign busy_o     = (state_q != IDLE);
  assign cfg_err_o  = cfg_err_q;

endmodule
